// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and master indices for the memory bus arbiter
package mem_bus_pkg;

    typedef enum logic {ARB, LOCKED} arb_state_e;

    typedef struct packed {
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    localparam logic MASTER_CPU = 1'b0;
    localparam logic MASTER_AUX = 1'b1;

endpackage

// File: rtl/mem_bus_resp_track.sv
// mem_bus_resp_track: one-cycle read response tracking and rdata/rvalid demux
module mem_bus_resp_track
    import mem_bus_pkg::*;
(
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        rd_fire_i,
    input  logic        owner_i,
    input  logic [31:0] mem_rdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o
);

    logic resp_valid_q, resp_valid_d;
    logic resp_owner_q, resp_owner_d;

    // capture whether this cycle's grant was a read and who issued it
    always_comb begin
        resp_valid_d = rd_fire_i;
        resp_owner_d = rd_fire_i ? owner_i : resp_owner_q;
    end

    // response register; reset drops any read in flight
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= MASTER_CPU;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
        end
    end

    assign m0_rvalid_o = resp_valid_q && resp_owner_q == MASTER_CPU;
    assign m1_rvalid_o = resp_valid_q && resp_owner_q == MASTER_AUX;
    assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : 32'd0;
    assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : 32'd0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between the CPU (m0) and an auxiliary master (m1)
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        m0_req_i,
    input  logic [3:0]  m0_wstrb_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    input  logic [3:0]  m1_wstrb_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wdata_i,
    input  logic        m1_lock_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        mem_enable_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    arb_state_e state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       m0_req, m1_req, m0_gnt, m1_gnt;
    mem_req_t   sel;

    // requests are masked during reset so no grant or memory strobe escapes
    assign m0_req = m0_req_i && rstn_i;
    assign m1_req = m1_req_i && rstn_i;

    // grant decision, lock tracking and m1 starvation counter
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        m0_gnt     = 1'b0;
        m1_gnt     = 1'b0;
        if (state_q == ARB) begin
            m1_gnt = m1_req && (!m0_req || wait_cnt_q == 8'(MAX_WAIT));
            m0_gnt = m0_req && !m1_gnt;
            if (m1_gnt && m1_lock_i) begin
                state_d    = LOCKED;
                lock_cnt_d = 8'd0;
            end
        end else begin
            m1_gnt     = m1_req;
            lock_cnt_d = lock_cnt_q + {7'd0, lock_cnt_q != 8'hFF};
            if (!m1_lock_i || lock_cnt_d >= 8'(LOCK_MAX))
                state_d = ARB;
        end
        wait_cnt_d = m1_gnt ? 8'd0 :
                     (m1_req && wait_cnt_q < 8'(MAX_WAIT)) ? wait_cnt_q + 8'd1 : wait_cnt_q;
    end

    // arbitration state and counters
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ARB;
            wait_cnt_q <= 8'd0;
            lock_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // memory side carries the winner's payload, zero when idle
    always_comb begin
        sel = m1_gnt ? mem_req_t'{m1_wstrb_i, m1_addr_i, m1_wdata_i} :
              m0_gnt ? mem_req_t'{m0_wstrb_i, m0_addr_i, m0_wdata_i} : '0;
    end

    assign m0_gnt_o     = m0_gnt;
    assign m1_gnt_o     = m1_gnt;
    assign mem_enable_o = m0_gnt || m1_gnt;
    assign mem_wstrb_o  = sel.wstrb;
    assign mem_addr_o   = sel.addr;
    assign mem_wdata_o  = sel.wdata;

    mem_bus_resp_track u_resp (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .rd_fire_i   (mem_enable_o && sel.wstrb == 4'd0),
        .owner_i     (m1_gnt ? MASTER_AUX : MASTER_CPU),
        .mem_rdata_i (mem_rdata_i),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o)
    );

endmodule
